// File: rtl/acquisition_controller_if.sv
// Signal bundle between the acquisition controller, the ADC stream, the sample RAM
// write port and the readout block.
interface acquisition_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              arm;
  logic              abort;
  logic              single;
  logic              trig_rising;
  logic [DATA_W-1:0] trig_level;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_we;
  logic              rd_activate;
  logic              rd_done;
  logic              busy;
  logic              triggered;
  logic              forced;
  logic [2:0]        state;

  modport master (
    output arm, abort, single, trig_rising, trig_level, adc_data, adc_valid, rd_done,
    input  mem_wr_addr, mem_wr_data, mem_we, rd_activate, busy, triggered, forced, state
  );

  modport slave (
    input  arm, abort, single, trig_rising, trig_level, adc_data, adc_valid, rd_done,
    output mem_wr_addr, mem_wr_data, mem_we, rd_activate, busy, triggered, forced, state
  );
endinterface

// File: rtl/acquisition_controller.sv
// Oscilloscope acquisition sequencer: arm, trigger search, DEPTH-sample capture,
// readout handshake and holdoff with optional auto re-arm.
module acquisition_controller #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int HOLDOFF_CYCLES = 5000000,
  parameter int AUTO_TIMEOUT   = 0
) (
  input logic                     clk_50mhz,
  input logic                     reset,
  acquisition_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READOUT = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam bit          TMO_EN    = (AUTO_TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST  = TMO_EN ? 32'(AUTO_TIMEOUT - 1) : 32'd0;
  localparam logic [31:0] HOLD_LAST = (HOLDOFF_CYCLES > 0) ? 32'(HOLDOFF_CYCLES - 1) : 32'd0;
  // Write pointer runs one past the last address so "all DEPTH written" is explicit.
  localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  function automatic logic level_cross(
    input logic              rising,
    input logic [DATA_W-1:0] prev,
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] lvl
  );
    if (rising) begin
      level_cross = (prev < lvl) && (cur >= lvl);
    end else begin
      level_cross = (prev > lvl) && (cur <= lvl);
    end
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              ract_q, ract_d;
  logic              busy_q, busy_d;
  logic              trig_q, trig_d;
  logic              forced_q, forced_d;
  logic [DATA_W-1:0] prev_sample_q, prev_sample_d;
  logic              prev_valid_q, prev_valid_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;
  logic [31:0]       hold_cnt_q, hold_cnt_d;
  logic [1:0]        ro_cnt_q, ro_cnt_d;
  logic              rd_done_prev_q, rd_done_prev_d;
  logic              abort_lat_q, abort_lat_d;

  logic real_trig_s;
  logic timeout_hit_s;
  logic rd_edge_s;
  logic hold_done_s;

  assign real_trig_s   = prev_valid_q &&
                         level_cross(bus.trig_rising, prev_sample_q, bus.adc_data, bus.trig_level);
  assign timeout_hit_s = TMO_EN && (tmo_cnt_q == TMO_LAST);
  // rd_done is only trusted from the third READOUT cycle onward.
  assign rd_edge_s     = bus.rd_done && !rd_done_prev_q && (ro_cnt_q == 2'd2);
  assign hold_done_s   = (hold_cnt_q >= HOLD_LAST);

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    addr_d         = addr_q;
    data_d         = data_q;
    we_d           = 1'b0;
    ract_d         = 1'b0;
    trig_d         = trig_q;
    forced_d       = forced_q;
    prev_sample_d  = prev_sample_q;
    prev_valid_d   = prev_valid_q;
    tmo_cnt_d      = tmo_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    ro_cnt_d       = ro_cnt_q;
    abort_lat_d    = abort_lat_q;
    rd_done_prev_d = bus.rd_done;

    case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d      = ST_ARMED;
          prev_valid_d = 1'b0;
          tmo_cnt_d    = 32'd0;
          trig_d       = 1'b0;
          forced_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARMED: begin
        if (TMO_EN && (tmo_cnt_q != TMO_LAST)) begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
        if (bus.abort) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end else if (bus.adc_valid && (real_trig_s || timeout_hit_s)) begin
          state_d  = ST_CAPTURE;
          we_d     = 1'b1;
          addr_d   = {ADDR_W{1'b0}};
          data_d   = bus.adc_data;
          ptr_d    = PTR_ONE;
          trig_d   = 1'b1;
          forced_d = !real_trig_s;
        end else if (bus.adc_valid) begin
          prev_sample_d = bus.adc_data;
          prev_valid_d  = 1'b1;
        end else begin
          state_d = ST_ARMED;
        end
      end

      ST_CAPTURE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end else if (ptr_q == PTR_FULL) begin
          state_d     = ST_READOUT;
          ract_d      = 1'b1;
          ro_cnt_d    = 2'd0;
          abort_lat_d = 1'b0;
        end else if (bus.adc_valid) begin
          we_d   = 1'b1;
          addr_d = ptr_q[ADDR_W-1:0];
          data_d = bus.adc_data;
          ptr_d  = ptr_q + PTR_ONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_READOUT: begin
        abort_lat_d = abort_lat_q || bus.abort;
        if (ro_cnt_q != 2'd2) begin
          ro_cnt_d = ro_cnt_q + 2'd1;
        end else begin
          ro_cnt_d = ro_cnt_q;
        end
        if (rd_edge_s && (abort_lat_q || bus.abort)) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end else if (rd_edge_s) begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = 32'd0;
        end else begin
          state_d = ST_READOUT;
        end
      end

      ST_HOLDOFF: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end else if (hold_done_s && bus.single) begin
          state_d = ST_IDLE;
          trig_d  = 1'b0;
        end else if (hold_done_s) begin
          state_d      = ST_ARMED;
          trig_d       = 1'b0;
          forced_d     = 1'b0;
          prev_valid_d = 1'b0;
          tmo_cnt_d    = 32'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        trig_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= {(ADDR_W+1){1'b0}};
      addr_q         <= {ADDR_W{1'b0}};
      data_q         <= {DATA_W{1'b0}};
      we_q           <= 1'b0;
      ract_q         <= 1'b0;
      busy_q         <= 1'b0;
      trig_q         <= 1'b0;
      forced_q       <= 1'b0;
      prev_sample_q  <= {DATA_W{1'b0}};
      prev_valid_q   <= 1'b0;
      tmo_cnt_q      <= 32'd0;
      hold_cnt_q     <= 32'd0;
      ro_cnt_q       <= 2'd0;
      rd_done_prev_q <= 1'b0;
      abort_lat_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      we_q           <= we_d;
      ract_q         <= ract_d;
      busy_q         <= busy_d;
      trig_q         <= trig_d;
      forced_q       <= forced_d;
      prev_sample_q  <= prev_sample_d;
      prev_valid_q   <= prev_valid_d;
      tmo_cnt_q      <= tmo_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      ro_cnt_q       <= ro_cnt_d;
      rd_done_prev_q <= rd_done_prev_d;
      abort_lat_q    <= abort_lat_d;
    end
  end

  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = data_q;
  assign bus.mem_we      = we_q;
  assign bus.rd_activate = ract_q;
  assign bus.busy        = busy_q;
  assign bus.triggered   = trig_q;
  assign bus.forced      = forced_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_acquisition_controller.sv
// Directed bench: trigger-comparator vector table plus hand-written capture,
// readout, holdoff, abort, timeout and reset sequences.
module tb_acquisition_controller;

  logic clk;
  logic rst_n;

  acquisition_controller_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  acquisition_controller_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  acquisition_controller #(.ADDR_W(8), .DATA_W(8), .HOLDOFF_CYCLES(10), .AUTO_TIMEOUT(0)) dut (
    .clk_50mhz(clk), .reset(rst_n), .bus(bus0)
  );
  acquisition_controller #(.ADDR_W(8), .DATA_W(8), .HOLDOFF_CYCLES(10), .AUTO_TIMEOUT(100)) dut_t (
    .clk_50mhz(clk), .reset(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int we_cnt0 = 0;
  int ract_cnt0 = 0;
  int we_cnt1 = 0;
  int bad1 = 0;
  logic ramp_on = 1'b0;
  logic [7:0] cap_mem [256];

  typedef struct {
    logic       rising;
    logic [7:0] level;
    logic [7:0] prev;
    logic [7:0] cur;
    logic       exp_trig;
  } vec_t;
  vec_t vecs [9];

  // Scoreboard of what the DUT writes into sample RAM.
  always @(negedge clk) begin
    if (bus0.mem_we) begin
      we_cnt0 <= we_cnt0 + 1;
      cap_mem[bus0.mem_wr_addr] <= bus0.mem_wr_data;
    end
    if (bus0.rd_activate) ract_cnt0 <= ract_cnt0 + 1;
    if (bus1.mem_we) begin
      we_cnt1 <= we_cnt1 + 1;
      if (bus1.mem_wr_data != 8'h10) bad1 <= bad1 + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (ramp_on) bus0.adc_data = bus0.adc_data + 8'd1;
  endtask

  task automatic wait_state0(input logic [2:0] st, input int max_cycles, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus0.state == st) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(found), 32'd1);
  endtask

  function automatic logic [31:0] outs0();
    return {8'h00, bus0.mem_wr_addr, bus0.mem_wr_data, bus0.mem_we, bus0.rd_activate,
            bus0.busy, bus0.triggered, bus0.forced, bus0.state};
  endfunction

  function automatic logic [31:0] outs1();
    return {8'h00, bus1.mem_wr_addr, bus1.mem_wr_data, bus1.mem_we, bus1.rd_activate,
            bus1.busy, bus1.triggered, bus1.forced, bus1.state};
  endfunction

  // Arm bus0 and feed a rising 0x00 -> 0xFF pair so a capture starts quickly.
  task automatic quick_capture0();
    bus0.trig_rising = 1'b1;
    bus0.trig_level  = 8'h80;
    bus0.arm = 1'b1;
    step();
    bus0.arm = 1'b0;
    bus0.adc_valid = 1'b1;
    bus0.adc_data  = 8'h00;
    step();
    bus0.adc_data = 8'hFF;
    step();
  endtask

  initial begin
    int n;
    int bad;
    int we_base;
    int ract_base;
    logic found;

    vecs[0] = '{1'b1, 8'h80, 8'h7F, 8'h80, 1'b1};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 8'h81, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h7F, 8'h7F, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h00, 8'hFF, 1'b1};
    vecs[4] = '{1'b0, 8'h40, 8'h41, 8'h40, 1'b1};
    vecs[5] = '{1'b0, 8'h40, 8'h40, 8'h3F, 1'b0};
    vecs[6] = '{1'b0, 8'h40, 8'h41, 8'h41, 1'b0};
    vecs[7] = '{1'b0, 8'h40, 8'hFF, 8'h00, 1'b1};
    vecs[8] = '{1'b1, 8'h00, 8'h00, 8'hFF, 1'b0};

    rst_n = 1'b0;
    bus0.arm = 1'b0; bus0.abort = 1'b0; bus0.single = 1'b0; bus0.trig_rising = 1'b1;
    bus0.trig_level = 8'h00; bus0.adc_data = 8'h00; bus0.adc_valid = 1'b0; bus0.rd_done = 1'b0;
    bus1.arm = 1'b0; bus1.abort = 1'b0; bus1.single = 1'b0; bus1.trig_rising = 1'b1;
    bus1.trig_level = 8'h00; bus1.adc_data = 8'h00; bus1.adc_valid = 1'b0; bus1.rd_done = 1'b0;
    step(); step();
    check("reset_outs0", outs0(), 32'd0);
    check("reset_outs1", outs1(), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", outs0(), 32'd0);

    // Trigger comparator table.
    for (int v = 0; v < 9; v++) begin
      bus0.trig_rising = vecs[v].rising;
      bus0.trig_level  = vecs[v].level;
      bus0.arm = 1'b1;
      step();
      bus0.arm = 1'b0;
      bus0.adc_valid = 1'b1;
      bus0.adc_data  = vecs[v].prev;
      step();
      bus0.adc_data = vecs[v].cur;
      step();
      bus0.adc_valid = 1'b0;
      check($sformatf("vec%0d_state", v), 32'(bus0.state), vecs[v].exp_trig ? 32'd2 : 32'd1);
      check($sformatf("vec%0d_we", v), 32'(bus0.mem_we), 32'(vecs[v].exp_trig));
      if (vecs[v].exp_trig) check($sformatf("vec%0d_data", v), 32'(bus0.mem_wr_data), 32'(vecs[v].cur));
      bus0.abort = 1'b1;
      step();
      bus0.abort = 1'b0;
      check($sformatf("vec%0d_idle", v), 32'(bus0.state), 32'd0);
    end

    // Rising ramp capture with stale rd_done through READOUT entry.
    bus0.trig_rising = 1'b1;
    bus0.trig_level  = 8'h80;
    bus0.single  = 1'b0;
    bus0.rd_done = 1'b1;
    bus0.arm = 1'b1;
    step();
    bus0.arm = 1'b0;
    check("ramp_armed", 32'(bus0.state), 32'd1);
    we_base   = we_cnt0;
    ract_base = ract_cnt0;
    bus0.adc_valid = 1'b1;
    bus0.adc_data  = 8'h00;
    ramp_on = 1'b1;
    wait_state0(3'd3, 600, "ramp_reach_readout");
    ramp_on = 1'b0;
    bus0.adc_valid = 1'b0;
    check("ramp_ract_first", 32'(bus0.rd_activate), 32'd1);
    check("ramp_we_count", 32'(we_cnt0 - we_base), 32'd256);
    check("ramp_addr0", 32'(cap_mem[0]), 32'h80);
    check("ramp_addr127", 32'(cap_mem[127]), 32'hFF);
    check("ramp_addr255", 32'(cap_mem[255]), 32'h7F);
    check("ramp_flags", {30'd0, bus0.triggered, bus0.forced}, 32'd2);
    step();
    check("ramp_ract_second", 32'(bus0.rd_activate), 32'd0);
    step(); step();
    bus0.rd_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus0.state != 3'd3) bad++;
    end
    check("readout_held", 32'(bad), 32'd0);
    bus0.rd_done = 1'b1;
    step();
    check("holdoff_entry", 32'(bus0.state), 32'd4);
    check("ract_single_pulse", 32'(ract_cnt0 - ract_base), 32'd1);
    check("no_we_in_readout", 32'(we_cnt0 - we_base), 32'd256);
    bus0.rd_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus0.state != 3'd4) bad++;
    end
    check("holdoff_len", 32'(bad), 32'd0);
    step();
    check("rearm_state", 32'(bus0.state), 32'd1);
    check("rearm_flags", {29'd0, bus0.busy, bus0.triggered, bus0.forced}, 32'd4);
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    check("abort_armed", {28'd0, bus0.busy, bus0.state}, 32'd0);

    // Falling trigger, one valid sample every fourth cycle.
    bus0.trig_rising = 1'b0;
    bus0.trig_level  = 8'h40;
    bus0.arm = 1'b1;
    step();
    bus0.arm = 1'b0;
    begin
      logic [7:0] fs [4];
      fs[0] = 8'h30; fs[1] = 8'h50; fs[2] = 8'h41; fs[3] = 8'h40;
      for (int i = 0; i < 4; i++) begin
        bus0.adc_valid = 1'b1;
        bus0.adc_data  = fs[i];
        step();
        bus0.adc_valid = 1'b0;
        if (i < 3) begin
          check($sformatf("fall_no_trig%0d", i), {28'd0, bus0.mem_we, bus0.state}, 32'd1);
          step(); step(); step();
        end
      end
    end
    check("fall_trig", {8'd0, bus0.mem_we, bus0.state, bus0.mem_wr_addr, bus0.mem_wr_data},
          {8'd0, 1'b1, 3'd2, 8'h00, 8'h40});

    // Abort mid-capture once address 37 is written; abort beats the pending sample.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus0.adc_valid = (i % 2 == 0);
      bus0.adc_data  = 8'(i);
      step();
      if (bus0.mem_we && bus0.mem_wr_addr == 8'd37) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_addr37", 32'(found), 32'd1);
    bus0.abort = 1'b1;
    bus0.adc_valid = 1'b1;
    step();
    bus0.abort = 1'b0;
    check("abort_capture", {27'd0, bus0.mem_we, bus0.busy, bus0.state}, 32'd0);
    we_base = we_cnt0;
    for (int i = 0; i < 20; i++) begin
      bus0.adc_valid = (i % 2 == 0);
      step();
    end
    bus0.adc_valid = 1'b0;
    check("no_we_after_abort", 32'(we_cnt0 - we_base), 32'd0);

    // Abort during READOUT is held until the rd_done edge.
    quick_capture0();
    wait_state0(3'd3, 400, "abortro_reach_readout");
    bus0.adc_valid = 1'b0;
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    check("abort_ro_latched", 32'(bus0.state), 32'd3);
    step(); step(); step(); step();
    bus0.rd_done = 1'b1;
    step();
    bus0.rd_done = 1'b0;
    check("abort_ro_idle", {28'd0, bus0.busy, bus0.state}, 32'd0);

    // Single-shot: HOLDOFF exits to IDLE.
    bus0.single = 1'b1;
    quick_capture0();
    wait_state0(3'd3, 400, "single_reach_readout");
    bus0.adc_valid = 1'b0;
    step(); step();
    bus0.rd_done = 1'b1;
    step();
    bus0.rd_done = 1'b0;
    check("single_holdoff", 32'(bus0.state), 32'd4);
    for (int i = 0; i < 9; i++) step();
    check("single_still_holdoff", 32'(bus0.state), 32'd4);
    step();
    check("single_idle", {28'd0, bus0.busy, bus0.state}, 32'd0);

    // Auto-timeout instance: constant 0x10 never crosses 0x80.
    bus1.trig_rising = 1'b1;
    bus1.trig_level  = 8'h80;
    bus1.adc_data    = 8'h10;
    bus1.adc_valid   = 1'b1;
    bus1.arm = 1'b1;
    step();
    bus1.arm = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus1.state != 3'd1) break;
      n++;
      step();
    end
    check("tmo_armed_cycles", 32'(n), 32'd100);
    check("tmo_trigger", {8'd0, bus1.forced, bus1.triggered, bus1.mem_we, bus1.state, bus1.mem_wr_data},
          {8'd0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h10});
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus1.state == 3'd3) begin
        found = 1'b1;
        break;
      end
      step();
    end
    bus1.adc_valid = 1'b0;
    check("tmo_reach_readout", 32'(found), 32'd1);
    check("tmo_we_count", 32'(we_cnt1), 32'd256);
    check("tmo_data", 32'(bad1), 32'd0);

    // Asynchronous reset in the middle of a capture.
    bus0.single = 1'b0;
    quick_capture0();
    for (int i = 0; i < 10; i++) step();
    check("pre_reset_capture", 32'(bus0.state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs0", outs0(), 32'd0);
    check("async_reset_outs1", outs1(), 32'd0);
    bus0.adc_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_idle", outs0(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acquisition_controller.md
Name: acquisition_controller

Overview:
- Sequences one oscilloscope acquisition: arm, wait for trigger, capture DEPTH ADC samples into the sample RAM write port, then start the sample readout block and wait for it to finish.
- Sits between the ADC sample stream, the 256x8 sample RAM write port and the readout block's activate/done handshake.
- Supports single-shot mode and auto re-arm after a holdoff.

Parameters:
ADDR_W, 8, sample RAM address width; DEPTH = 2**ADDR_W samples per capture
DATA_W, 8, sample width
HOLDOFF_CYCLES, 5000000, clk_50mhz cycles spent in HOLDOFF after readout (0.1 s)
AUTO_TIMEOUT, 0, cycles in ARMED without trigger before forced trigger; 0 disables

Ports:
clk_50mhz  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
arm  in  1  start acquisition; sampled only in IDLE
abort  in  1  return to IDLE (see rules)
single  in  1  1 = one-shot, 0 = re-arm after holdoff; sampled on HOLDOFF exit
trig_rising  in  1  1 = rising-edge trigger, 0 = falling
trig_level  in  DATA_W  trigger threshold, unsigned
adc_data  in  DATA_W  sample
adc_valid  in  1  adc_data valid this cycle
mem_wr_addr  out  ADDR_W  RAM write address
mem_wr_data  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe, one cycle per sample
rd_activate  out  1  one-cycle start pulse to readout block
rd_done  in  1  readout block done level
busy  out  1  high in any state except IDLE
triggered  out  1  high from trigger capture until IDLE/ARMED re-entry
forced  out  1  last trigger came from AUTO_TIMEOUT
state  out  3  IDLE=0 ARMED=1 CAPTURE=2 READOUT=3 HOLDOFF=4

Behaviour:
- Reset (reset=0, asynchronous) puts the block in IDLE with all outputs 0 and all counters 0.
- All outputs are registered.
- IDLE: arm=1 moves to ARMED next cycle; prev_valid is cleared and the timeout counter is cleared.
- ARMED, first adc_valid: loads prev_sample and sets prev_valid. No trigger is possible on this sample.
- ARMED, later adc_valid: rising trigger when prev_sample < trig_level AND adc_data >= trig_level; falling trigger when prev_sample > trig_level AND adc_data <= trig_level.
  - Non-trigger samples update prev_sample.
- ARMED, trigger action: the trigger sample is written at address 0 (mem_we=1 next cycle, addr 0). Set triggered, clear forced, go to CAPTURE.
- ARMED, AUTO_TIMEOUT: if AUTO_TIMEOUT != 0, the counter increments every cycle in ARMED. At count == AUTO_TIMEOUT-1, the next adc_valid sample is written as the trigger sample and forced=1 is set.
  - A real trigger on the same sample takes precedence: forced=0.
- CAPTURE: each adc_valid writes at the next address, one mem_we pulse per sample, no other writes.
  - After the write to address DEPTH-1, go to READOUT. The address counter must not wrap into a further write.
  - Total writes per capture are exactly DEPTH.
- READOUT: rd_activate=1 for exactly the first cycle in READOUT. The rd_done level is ignored during that cycle and the next one.
  - Afterwards, a 0->1 edge of rd_done (registered previous value) moves to HOLDOFF.
  - If rd_done is already 1 after the masked cycles, wait for it to drop and rise again.
- HOLDOFF: the counter runs HOLDOFF_CYCLES cycles; HOLDOFF_CYCLES=0 means exit next cycle.
  - On exit: single=1 goes to IDLE; single=0 goes to ARMED, clearing triggered, forced and prev_valid.
- abort in ARMED, CAPTURE or HOLDOFF: go to IDLE next cycle; mem_we is deasserted and a partial capture is abandoned.
- abort in READOUT: latched. After the rd_done edge, go to IDLE instead of HOLDOFF.
- abort and trigger in the same cycle: abort wins and no write occurs.
- arm outside IDLE is ignored.
- adc_valid gaps of any length are legal in ARMED and CAPTURE.

Test Plan:
- Rising trigger: trig_level=0x80, ramp adc_data 0x00..0xFF, valid every cycle -> trigger on 0x80; addr0=0x80, addr255=0x7F (after wrap), exactly 256 mem_we; then rd_activate single pulse.
- Falling trigger, valid every 4th cycle: level=0x40, samples 0x50,0x41,0x40 -> trigger at 0x40 written to addr 0; first-sample-after-arm of 0x30 never triggers.
- Auto timeout: AUTO_TIMEOUT=100, constant 0x10, level=0x80 -> forced=1, capture of 256 samples of 0x10 after ~100 cycles.
- Readout handshake: hold rd_done=1 stale through READOUT entry, drop after 3 cycles, raise after 20 -> HOLDOFF entered 1 cycle after rise; rd_activate exactly one pulse.
- Modes/holdoff: HOLDOFF_CYCLES=10, single=0 -> ARMED again 10 cycles later; single=1 -> IDLE, busy=0.
- Abort/reset: abort mid-CAPTURE at addr 37 -> IDLE, no further mem_we. Abort in READOUT -> IDLE after rd_done. Async reset mid-CAPTURE -> all outputs 0 immediately.
